keypad_entry_ctrl: RTL
======================

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 The block SHALL have parameter DIGITS, default 3, giving the BCD digits per operand.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 27000000, giving the inactivity limit in clk cycles.
REQ-003 The block SHALL have port clk, input, 1, rising-edge system clock.
REQ-004 The block SHALL have port n_reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port key_code, input, 4, code of the key just decoded.
REQ-006 The block SHALL have port key_valid, input, 1, one-cycle strobe qualifying key_code.
REQ-007 The block SHALL have port op_ready, input, 1, arithmetic unit accepts operands.
REQ-008 The block SHALL have port res_valid, input, 1, arithmetic unit result available.
REQ-009 The block SHALL have port operand_a, output, 4*DIGITS, BCD operand A, most significant digit in the top nibble.
REQ-010 The block SHALL have port operand_b, output, 4*DIGITS, BCD operand B, same format as operand_a.
REQ-011 The block SHALL have port op_valid, output, 1, operand request to the arithmetic unit.
REQ-012 The block SHALL have port disp_sel, output, 2, display source: 0 = A, 1 = B, 2 = result.
REQ-013 The block SHALL have port busy, output, 1, high while a calculation is outstanding.
REQ-014 The block SHALL have port timeout, output, 1, one-cycle pulse on inactivity abort.

Function
REQ-015 The block SHALL implement the states IDLE, ENTER_A, ENTER_B, REQ, WAIT_RES and SHOW.
REQ-016 Digit keys SHALL be key codes 0x0-0x9; 0xA SHALL mean next, 0xF equals and 0xE clear; 0xB-0xD SHALL be ignored in every state.
REQ-017 In IDLE, a digit SHALL load A = digit with count_a = 1 and move to ENTER_A; all other keys SHALL be ignored.
REQ-018 In ENTER_A or ENTER_B, a digit SHALL shift the operand left one nibble and insert the digit in the low nibble only if count < DIGITS; otherwise the digit SHALL be ignored with no wrap.
REQ-019 In ENTER_A, next SHALL clear B and count_b and move to ENTER_B; equals SHALL be ignored.
REQ-020 In ENTER_B, equals SHALL move to REQ only if count_b >= 1; next SHALL be ignored.
REQ-021 Clear in ENTER_A, ENTER_B or SHOW SHALL zero A, B and both counts and move to IDLE on the next edge.
REQ-022 In REQ, op_valid SHALL be 1 and SHALL stay high until op_valid && op_ready; the state SHALL then move to WAIT_RES; operands SHALL be stable throughout.
REQ-023 In WAIT_RES, res_valid SHALL move the state to SHOW; res_valid in any other state SHALL be ignored.
REQ-024 In SHOW, a digit SHALL load A = digit, clear B, set count_a = 1 and move to ENTER_A.
REQ-025 All keys in REQ and WAIT_RES, including clear, SHALL be ignored.
REQ-026 disp_sel SHALL be 0 in IDLE and ENTER_A, 1 in ENTER_B, and 2 in REQ, WAIT_RES and SHOW.
REQ-027 busy SHALL be 1 exactly in REQ and WAIT_RES.
REQ-028 All outputs SHALL be registered with one clk of latency from key_valid, op_ready or res_valid.

Reset
REQ-029 Asserting n_reset SHALL force IDLE, operand_a = 0, operand_b = 0, counts = 0, op_valid = 0, disp_sel = 0, busy = 0, timeout = 0 and the timeout counter = 0, including mid-handshake.

Configuration
REQ-030 With KEYPAD_TIMEOUT_EN defined, a counter SHALL run in ENTER_A, ENTER_B and SHOW, and SHALL be zeroed by any key_valid or any state change.
REQ-031 With KEYPAD_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYCLES-1 SHALL perform the clear action of REQ-021 and pulse timeout for one cycle; a key_valid in that same cycle SHALL win and cancel the timeout.
REQ-032 Without KEYPAD_TIMEOUT_EN, no counter SHALL be built and timeout SHALL be constant 0.

Structure
REQ-033 A shared package SHALL hold the state enum, the key constants KEY_NEXT = 4'hA, KEY_EQ = 4'hF and KEY_CLR = 4'hE, and the disp_sel encodings.
REQ-034 The sub-module bcd_entry_reg, which holds a shift register, a digit counter, load, clear and saturation, SHALL be instantiated twice, once for A and once for B.

Verification
REQ-035 Keys 1,2,3,4, then A, then 5, then F -> operand_a = 0x123, operand_b = 0x005, op_valid = 1, disp_sel = 2.
REQ-036 In REQ with op_ready held at 0 for 10 cycles, then driven to 1 -> op_valid stays 1, busy = 1, leaves REQ one cycle after the handshake; res_valid -> SHOW.
REQ-037 Keys 7, A, then F with B empty -> remains in ENTER_B; keys E and 3 in WAIT_RES -> ignored, operands unchanged.
REQ-038 Key E in ENTER_B with A = 0x042 -> next cycle IDLE, operand_a = 0, operand_b = 0, disp_sel = 0.
REQ-039 n_reset asserted during REQ -> op_valid = 0 asynchronously, state IDLE.
REQ-040 With KEYPAD_TIMEOUT_EN and TIMEOUT_CYCLES = 16, key 9 then idle -> timeout pulses once after 16 cycles and the state returns to IDLE; a key at cycle 15 -> no timeout.

Source files
------------

// File: rtl/keypad_entry_ctrl_pkg.sv
// rtl/keypad_entry_ctrl_pkg.sv - shared types and constants for the keypad entry controller
//
// Purpose : FSM state enum, special key codes, display-source encodings and
//           the state-to-display mapping used by keypad_entry_ctrl.
// Ports   : none (package)
package keypad_entry_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTER_A  = 3'd1,
        ST_ENTER_B  = 3'd2,
        ST_REQ      = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_SHOW     = 3'd5
    } state_t;

    localparam logic [3:0] KEY_NEXT = 4'hA;
    localparam logic [3:0] KEY_EQ   = 4'hF;
    localparam logic [3:0] KEY_CLR  = 4'hE;

    localparam logic [1:0] DISP_A   = 2'd0;
    localparam logic [1:0] DISP_B   = 2'd1;
    localparam logic [1:0] DISP_RES = 2'd2;

    function automatic logic [1:0] disp_for_state(input state_t s);
        case (s)
            ST_ENTER_B:                    return DISP_B;
            ST_REQ, ST_WAIT_RES, ST_SHOW:  return DISP_RES;
            default:                       return DISP_A;
        endcase
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// rtl/bcd_entry_reg.sv - saturating BCD digit-entry shift register
//
// Purpose : holds one operand as DIGITS BCD nibbles plus a count of digits
//           entered. Digits shift in at the low nibble; once DIGITS digits
//           are held, further digits are dropped rather than wrapping.
// Ports   : clk, n_reset  - clock, asynchronous active-low reset
//           i_clear       - zero value and count (highest priority)
//           i_load        - value = i_digit, count = 1
//           i_shift       - shift i_digit in if count < DIGITS
//           i_digit       - BCD digit to load/shift
//           o_value       - operand, most significant digit in top nibble
//           o_count       - number of digits entered
import keypad_entry_ctrl_pkg::*;

module bcd_entry_reg #(
    parameter  int DIGITS = 3,
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                i_clear,
    input  logic                i_load,
    input  logic                i_shift,
    input  logic [3:0]          i_digit,
    output logic [4*DIGITS-1:0] o_value,
    output logic [CW-1:0]       o_count
);

    logic [4*DIGITS-1:0] r_value;
    logic [CW-1:0]       r_count;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_value <= (4*DIGITS)'(i_digit);
            r_count <= CW'(1);
        end else if (i_shift && (r_count < CW'(DIGITS))) begin
            // Top nibble is still zero here, so the left shift loses nothing.
            r_value <= (r_value << 4) | (4*DIGITS)'(i_digit);
            r_count <= r_count + CW'(1);
        end
    end

    assign o_value = r_value;
    assign o_count = r_count;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - keypad operand entry and arithmetic-unit handshake controller
//
// Purpose : collects two BCD operands from decoded key strobes, requests a
//           calculation with a valid/ready handshake, waits for the result
//           and selects the display source. Optional inactivity timeout is
//           built only when KEYPAD_TIMEOUT_EN is defined.
// Ports   : clk, n_reset        - clock, asynchronous active-low reset
//           key_code, key_valid - decoded key and its one-cycle strobe
//           op_ready            - arithmetic unit accepts operands
//           res_valid           - arithmetic unit result available
//           operand_a/operand_b - BCD operands (MS digit in top nibble)
//           op_valid            - operand request
//           disp_sel            - display source (0 A, 1 B, 2 result)
//           busy                - calculation outstanding
//           timeout             - one-cycle pulse on inactivity abort
import keypad_entry_ctrl_pkg::*;

module keypad_entry_ctrl #(
    parameter int DIGITS         = 3,
    parameter int TIMEOUT_CYCLES = 27000000
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [3:0]          key_code,
    input  logic                key_valid,
    input  logic                op_ready,
    input  logic                res_valid,
    output logic [4*DIGITS-1:0] operand_a,
    output logic [4*DIGITS-1:0] operand_b,
    output logic                op_valid,
    output logic [1:0]          disp_sel,
    output logic                busy,
    output logic                timeout
);

    localparam int CW = $clog2(DIGITS + 1);

    state_t         r_state;
    state_t         w_next_state;
    logic           r_op_valid;
    logic [1:0]     r_disp_sel;
    logic           r_busy;

    logic           w_is_digit;
    logic           w_clear_all;
    logic           w_a_load;
    logic           w_a_shift;
    logic           w_b_clear;
    logic           w_b_shift;
    logic [CW-1:0]  w_count_b;
    logic [CW-1:0]  w_unused_count_a;
    logic           w_to_fire;

    assign w_is_digit = (key_code <= 4'd9);

    // Next state and operand-register strobes. Keys in REQ and WAIT_RES,
    // including clear, are deliberately not decoded.
    always_comb begin
        w_next_state = r_state;
        w_clear_all  = 1'b0;
        w_a_load     = 1'b0;
        w_a_shift    = 1'b0;
        w_b_clear    = 1'b0;
        w_b_shift    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (key_valid && w_is_digit) begin
                    w_a_load     = 1'b1;
                    w_next_state = ST_ENTER_A;
                end
            end
            ST_ENTER_A: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        w_a_shift = 1'b1;
                    end else if (key_code == KEY_NEXT) begin
                        w_b_clear    = 1'b1;
                        w_next_state = ST_ENTER_B;
                    end else if (key_code == KEY_CLR) begin
                        w_clear_all  = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_ENTER_B: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        w_b_shift = 1'b1;
                    end else if (key_code == KEY_EQ) begin
                        // An empty B operand cannot start a calculation.
                        if (w_count_b != '0) begin
                            w_next_state = ST_REQ;
                        end
                    end else if (key_code == KEY_CLR) begin
                        w_clear_all  = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_REQ: begin
                if (r_op_valid && op_ready) begin
                    w_next_state = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (res_valid) begin
                    w_next_state = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        w_a_load     = 1'b1;
                        w_b_clear    = 1'b1;
                        w_next_state = ST_ENTER_A;
                    end else if (key_code == KEY_CLR) begin
                        w_clear_all  = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        // Fire is already qualified by no key this cycle, so it never
        // competes with a key action above.
        if (w_to_fire) begin
            w_clear_all  = 1'b1;
            w_next_state = ST_IDLE;
        end
    end

    // FSM state and registered outputs, all derived from the next state so
    // they change on the same edge as the state.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= ST_IDLE;
            r_op_valid <= 1'b0;
            r_disp_sel <= DISP_A;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_op_valid <= (w_next_state == ST_REQ);
            r_disp_sel <= disp_for_state(w_next_state);
            r_busy     <= (w_next_state == ST_REQ) || (w_next_state == ST_WAIT_RES);
        end
    end

    assign op_valid = r_op_valid;
    assign disp_sel = r_disp_sel;
    assign busy     = r_busy;

    bcd_entry_reg #(.DIGITS(DIGITS)) u_reg_a (
        .clk     (clk),
        .n_reset (n_reset),
        .i_clear (w_clear_all),
        .i_load  (w_a_load),
        .i_shift (w_a_shift),
        .i_digit (key_code),
        .o_value (operand_a),
        .o_count (w_unused_count_a)
    );

    bcd_entry_reg #(.DIGITS(DIGITS)) u_reg_b (
        .clk     (clk),
        .n_reset (n_reset),
        .i_clear (w_clear_all | w_b_clear),
        .i_load  (1'b0),
        .i_shift (w_b_shift),
        .i_digit (key_code),
        .o_value (operand_b),
        .o_count (w_count_b)
    );

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;
    logic          w_timed;

    assign w_timed   = (r_state == ST_ENTER_A) || (r_state == ST_ENTER_B) ||
                       (r_state == ST_SHOW);
    // A key in the terminal cycle counts as activity and cancels the abort.
    assign w_to_fire = w_timed && !key_valid && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_fire;
            if (key_valid || (w_next_state != r_state) || !w_timed) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_cfg;

    assign w_to_fire    = 1'b0;
    assign timeout      = 1'b0;
    assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

endmodule
